sdram_slot_arbiter: RTL and testbench
=====================================

// Module: sdram_slot_arbiter
// PURPOSE
//  Upstream request stage for the byte-wide single-port SDRAM controller. Arbitrates three
//  requestors onto the controller's shared addr/we/din/oeA/oeB port: CPU r/w (A), PPU/video
//  read (B), loader/DMA write (C). One request per clkref slot. Outputs are held stable for
//  the whole slot. Read data is returned at the next slot boundary. Inserts idle
//  (auto-refresh) slots and holds off all traffic until SDRAM init completes.
// PARAMETERS
//  INIT_SLOTS    17'h14c10  slots after reset before first grant (covers controller init)
//  REFRESH_GAP   8          max consecutive busy slots; next slot is forced idle
// PORTS
//  clk          in   1   SDRAM clock (same clk as controller); single clock domain
//  reset_n      in   1   asynchronous, active-low reset
//  clkref       in   1   system reference clock, sampled in clk; rising edge = slot boundary
//  a_req        in   1   CPU request, level, held until a_ack
//  a_we         in   1   CPU write(1)/read(0), stable while a_req
//  a_addr       in   25  CPU byte address
//  a_din        in   8   CPU write data
//  a_ack        out  1   1-cycle pulse: access complete; a_dout valid for reads
//  a_dout       out  8   CPU read data, held until next A read completes
//  b_req        in   1   video read request, level, held until b_ack
//  b_addr       in   25  video byte address
//  b_ack        out  1   1-cycle completion pulse
//  b_dout       out  8   video read data, held
//  c_req        in   1   loader write request, level, held until c_ack
//  c_addr       in   25  loader byte address
//  c_din        in   8   loader write data
//  c_ack        out  1   1-cycle completion pulse
//  mem_addr     out  25  to controller addr
//  mem_we       out  1   to controller we
//  mem_din      out  8   to controller din
//  mem_oeA      out  1   to controller oeA (CPU reads)
//  mem_oeB      out  1   to controller oeB (video reads)
//  mem_doutA    in   8   from controller doutA
//  mem_doutB    in   8   from controller doutB
// BEHAVIOUR
//  - Reset: all outputs 0, grant = NONE, rr pointer = A, busy_cnt = 0, init_cnt = INIT_SLOTS.
//  - clkref_q <= clkref; slot = clkref & ~clkref_q. clkref must stay high >= 2 clk cycles.
//    The controller sits in its FIRST state while clkref is high, so outputs updated in the
//    slot cycle are stable before the controller's command state.
//  - In a slot cycle, in this order:
//    1) Retire the previous grant. A read: a_dout <= mem_doutA. B: b_dout <= mem_doutB.
//       Pulse that port's ack next cycle (registered).
//    2) If init_cnt != 0: decrement it, grant NONE.
//    3) Else if busy_cnt == REFRESH_GAP: grant NONE, busy_cnt <= 0.
//    4) Else pick a winner among requests, masking the port retired in step 1.
//       - B has fixed highest priority.
//       - A and C alternate via the rr pointer; the pointer flips only when A or C wins.
//       - Winner present: busy_cnt++. No winner: grant NONE, busy_cnt <= 0.
//  - Grant drives mem_* for the whole slot:
//    - A read: oeA=1, we=0.  A write: we=1, din=a_din.
//    - B: oeB=1.  C: we=1, din=c_din.
//    - NONE: we=oeA=oeB=0 (controller refreshes); addr/din hold their last value.
//  - Latency: request seen at slot N -> ack 1 cycle after slot N+1. Worst case for B is 2 slots.
//  - Masking rule: a port acked at boundary N cannot win at N. A requestor must drop req
//    in the cycle it sees ack, or it is re-served at N+1.
//  - Port inputs are sampled only in the slot cycle and registered. Changes mid-slot have no
//    effect. Dropping req before ack is a protocol error: the access still completes and
//    ack still pulses.
//  - Async reset mid-slot clears we/oe immediately. The in-flight access is lost, with no ack.
// STRUCTURE
//  - Shared package sdram_pkg: grant_t enum {GNT_NONE, GNT_A, GNT_B, GNT_C}; SDRAM_AW = 25.
//  - Single sub-module: sdram_slot_timer (clkref edge detect + init_cnt + busy_cnt).
//    The arbiter core and output registers stay in the top.
// TESTING
//  1) Reset, INIT_SLOTS=4 with a_req held: no mem_* activity for 4 slots; A granted at slot 5.
//  2) A read 0x0000001, controller model returns 0x5A: a_ack pulses once, a_dout=0x5A,
//     mem_oeA high exactly one slot.
//  3) b_req and a_req both asserted at the same slot: B served first, A in the next slot,
//     with mem_oeB/mem_oeA in the correct slots.
//  4) a_req and c_req held continuously, REFRESH_GAP=8: grants alternate A,C; the 9th slot is
//     idle (we=oe=0); no port is starved.
//  5) C writes 0x1FFFFFF, data 0xA5 back-to-back: mem_we=1, mem_din=0xA5, mem_addr=0x1FFFFFF;
//     the same port is never granted in two consecutive slots.
//  6) Assert reset_n=0 mid A-write slot: mem_we drops asynchronously; no a_ack; after release
//     the init hold-off restarts.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM request path.
package sdram_pkg;

    localparam int unsigned SDRAM_AW = 25;
    localparam int unsigned SDRAM_DW = 8;
    localparam int unsigned INIT_W   = 17;

    // Port that owns the current slot; GNT_NONE lets the controller refresh.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2,
        GNT_C    = 2'd3
    } grant_t;

    // Command presented to the controller for the duration of one slot.
    typedef struct packed {
        logic [SDRAM_AW-1:0] addr;
        logic [SDRAM_DW-1:0] din;
        logic                we;
        logic                oea;
        logic                oeb;
    } mem_cmd_t;

endpackage

// File: rtl/sdram_slot_timer.sv
// Slot boundary detection, post-reset init hold-off and refresh spacing counter.
import sdram_pkg::*;

module sdram_slot_timer #(
    parameter logic [INIT_W-1:0] INIT_SLOTS  = 17'h14c10,
    parameter int unsigned       REFRESH_GAP = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clkref,
    input  logic win,
    output logic slot_c,
    output logic init_done_c,
    output logic refresh_due_c
);

    localparam int unsigned BW = $clog2(REFRESH_GAP + 1);

    logic              clkref_q;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [BW-1:0]     busy_cnt_q, busy_cnt_d;

    assign slot_c        = clkref & ~clkref_q;
    assign init_done_c   = (init_cnt_q == '0);
    assign refresh_due_c = (busy_cnt_q == BW'(REFRESH_GAP));

    // Counters advance only on slot boundaries; win is meaningful only when arbitration ran.
    always_comb begin
        init_cnt_d = init_cnt_q;
        busy_cnt_d = busy_cnt_q;
        if (slot_c) begin
            if (!init_done_c) begin
                init_cnt_d = init_cnt_q - INIT_W'(1);
            end else if (refresh_due_c) begin
                busy_cnt_d = '0;
            end else if (win) begin
                busy_cnt_d = busy_cnt_q + BW'(1);
            end else begin
                busy_cnt_d = '0;
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkref_q   <= 1'b0;
            init_cnt_q <= INIT_SLOTS;
            busy_cnt_q <= '0;
        end else begin
            clkref_q   <= clkref;
            init_cnt_q <= init_cnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Three-port slot arbiter in front of the single-port SDRAM controller.
import sdram_pkg::*;

module sdram_slot_arbiter #(
    parameter logic [INIT_W-1:0] INIT_SLOTS  = 17'h14c10,
    parameter int unsigned       REFRESH_GAP = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clkref,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [SDRAM_AW-1:0] a_addr,
    input  logic [SDRAM_DW-1:0] a_din,
    output logic                a_ack,
    output logic [SDRAM_DW-1:0] a_dout,
    input  logic                b_req,
    input  logic [SDRAM_AW-1:0] b_addr,
    output logic                b_ack,
    output logic [SDRAM_DW-1:0] b_dout,
    input  logic                c_req,
    input  logic [SDRAM_AW-1:0] c_addr,
    input  logic [SDRAM_DW-1:0] c_din,
    output logic                c_ack,
    output logic [SDRAM_AW-1:0] mem_addr,
    output logic                mem_we,
    output logic [SDRAM_DW-1:0] mem_din,
    output logic                mem_oeA,
    output logic                mem_oeB,
    input  logic [SDRAM_DW-1:0] mem_doutA,
    input  logic [SDRAM_DW-1:0] mem_doutB
);

    logic slot_c, init_done_c, refresh_due_c;

    grant_t   grant_q, grant_d, winner_c;
    logic     rr_q, rr_d;
    mem_cmd_t cmd_q, cmd_d;
    logic     a_ack_q, a_ack_d, b_ack_q, b_ack_d, c_ack_q, c_ack_d;
    logic [SDRAM_DW-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
    logic     a_ok_c, b_ok_c, c_ok_c;

    sdram_slot_timer #(
        .INIT_SLOTS  (INIT_SLOTS),
        .REFRESH_GAP (REFRESH_GAP)
    ) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .clkref        (clkref),
        .win           (winner_c != GNT_NONE),
        .slot_c        (slot_c),
        .init_done_c   (init_done_c),
        .refresh_due_c (refresh_due_c)
    );

    // Winner selection: the port being retired is masked, B first, A/C alternate (rr_q=1 favours C).
    always_comb begin
        winner_c = GNT_NONE;
        a_ok_c   = a_req && (grant_q != GNT_A);
        b_ok_c   = b_req && (grant_q != GNT_B);
        c_ok_c   = c_req && (grant_q != GNT_C);
        if (init_done_c && !refresh_due_c) begin
            if (b_ok_c) begin
                winner_c = GNT_B;
            end else if (a_ok_c && (!c_ok_c || !rr_q)) begin
                winner_c = GNT_A;
            end else if (c_ok_c) begin
                winner_c = GNT_C;
            end
        end
    end

    // Slot cycle: retire the previous grant, then load the new command for the whole slot.
    always_comb begin
        grant_d  = grant_q;
        rr_d     = rr_q;
        cmd_d    = cmd_q;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        c_ack_d  = 1'b0;
        a_dout_d = a_dout_q;
        b_dout_d = b_dout_q;
        if (slot_c) begin
            case (grant_q)
                GNT_A: begin
                    a_ack_d = 1'b1;
                    if (cmd_q.oea) a_dout_d = mem_doutA;
                end
                GNT_B: begin
                    b_ack_d  = 1'b1;
                    b_dout_d = mem_doutB;
                end
                GNT_C:   c_ack_d = 1'b1;
                default: ;
            endcase
            grant_d   = winner_c;
            cmd_d.we  = 1'b0;
            cmd_d.oea = 1'b0;
            cmd_d.oeb = 1'b0;
            case (winner_c)
                GNT_A: begin
                    cmd_d.addr = a_addr;
                    cmd_d.we   = a_we;
                    cmd_d.oea  = ~a_we;
                    if (a_we) cmd_d.din = a_din;
                    rr_d = 1'b1;
                end
                GNT_B: begin
                    cmd_d.addr = b_addr;
                    cmd_d.oeb  = 1'b1;
                end
                GNT_C: begin
                    cmd_d.addr = c_addr;
                    cmd_d.we   = 1'b1;
                    cmd_d.din  = c_din;
                    rr_d       = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Arbiter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q  <= GNT_NONE;
            rr_q     <= 1'b0;
            cmd_q    <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            c_ack_q  <= 1'b0;
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            cmd_q    <= cmd_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            c_ack_q  <= c_ack_d;
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign c_ack    = c_ack_q;
    assign a_dout   = a_dout_q;
    assign b_dout   = b_dout_q;
    assign mem_addr = cmd_q.addr;
    assign mem_din  = cmd_q.din;
    assign mem_we   = cmd_q.we;
    assign mem_oeA  = cmd_q.oea;
    assign mem_oeB  = cmd_q.oeb;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed and random slot-level checks of sdram_slot_arbiter against a per-slot reference model.
module tb_sdram_slot_arbiter;

    localparam int INIT = 4;
    localparam int GAP  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clkref = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [24:0] a_addr = '0;
    logic [7:0]  a_din = '0;
    logic        a_ack;
    logic [7:0]  a_dout;
    logic        b_req = 1'b0;
    logic [24:0] b_addr = '0;
    logic        b_ack;
    logic [7:0]  b_dout;
    logic        c_req = 1'b0;
    logic [24:0] c_addr = '0;
    logic [7:0]  c_din = '0;
    logic        c_ack;
    logic [24:0] mem_addr;
    logic        mem_we, mem_oeA, mem_oeB;
    logic [7:0]  mem_din;
    logic [7:0]  mem_doutA = '0, mem_doutB = '0;

    always #5 clk = ~clk;

    sdram_slot_arbiter #(
        .INIT_SLOTS  (17'(INIT)),
        .REFRESH_GAP (GAP)
    ) dut (
        .clk (clk), .reset_n (reset_n), .clkref (clkref),
        .a_req (a_req), .a_we (a_we), .a_addr (a_addr), .a_din (a_din),
        .a_ack (a_ack), .a_dout (a_dout),
        .b_req (b_req), .b_addr (b_addr), .b_ack (b_ack), .b_dout (b_dout),
        .c_req (c_req), .c_addr (c_addr), .c_din (c_din), .c_ack (c_ack),
        .mem_addr (mem_addr), .mem_we (mem_we), .mem_din (mem_din),
        .mem_oeA (mem_oeA), .mem_oeB (mem_oeB),
        .mem_doutA (mem_doutA), .mem_doutB (mem_doutB)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: ports are 0=none, 1=A, 2=B, 3=C.
    int          m_init, m_busy, m_last, m_last_ac;
    logic [24:0] m_addr;
    logic [7:0]  m_din, m_adout, m_bdout;
    bit          m_a_read;
    bit          hold;
    int          n_oea, n_we;

    // Controller memory contents as seen by reads.
    function automatic logic [7:0] rd_data(input logic [24:0] a);
        return a[7:0] ^ 8'h5B;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init = INIT; m_busy = 0; m_last = 0; m_last_ac = 3;
        m_addr = '0; m_din = '0; m_adout = '0; m_bdout = '0; m_a_read = 0;
    endtask

    // One full slot: predict, raise clkref, check command/acks/data, optionally reset mid-slot.
    task automatic slot_step(input bit rst_mid);
        int   g, ret;
        bit   a_ok, b_ok, c_ok;
        logic [2:0] exp_ack;
        logic e_we, e_oea, e_oeb;
        ret = m_last;
        if (ret == 1 && m_a_read) m_adout = rd_data(m_addr);
        if (ret == 2) m_bdout = rd_data(m_addr);
        exp_ack = {ret == 1, ret == 2, ret == 3};
        g = 0;
        if (m_init > 0) begin
            m_init--;
        end else if (m_busy == GAP) begin
            m_busy = 0;
        end else begin
            a_ok = a_req && ret != 1;
            b_ok = b_req && ret != 2;
            c_ok = c_req && ret != 3;
            if (b_ok) g = 2;
            else if (a_ok && c_ok) g = (m_last_ac == 1) ? 3 : 1;
            else if (a_ok) g = 1;
            else if (c_ok) g = 3;
            if (g == 1 || g == 3) m_last_ac = g;
            m_busy = (g != 0) ? m_busy + 1 : 0;
        end
        e_we = 0; e_oea = 0; e_oeb = 0;
        case (g)
            1: begin
                m_addr = a_addr; e_we = a_we; e_oea = !a_we; m_a_read = !a_we;
                if (a_we) m_din = a_din;
            end
            2: begin m_addr = b_addr; e_oeb = 1; end
            3: begin m_addr = c_addr; m_din = c_din; e_we = 1; end
            default: ;
        endcase
        m_last = g;

        @(negedge clk) clkref = 1'b1;
        @(posedge clk) #1;
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_din", 32'(mem_din), 32'(m_din));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_oeA", 32'(mem_oeA), 32'(e_oea));
        check("mem_oeB", 32'(mem_oeB), 32'(e_oeb));
        check("acks", 32'({a_ack, b_ack, c_ack}), 32'(exp_ack));
        check("a_dout", 32'(a_dout), 32'(m_adout));
        check("b_dout", 32'(b_dout), 32'(m_bdout));
        if (mem_oeA === 1'b1) n_oea++;
        if (mem_we === 1'b1) n_we++;
        @(posedge clk) #1;
        check("ack_pulse_width", 32'({a_ack, b_ack, c_ack}), 32'(0));
        mem_doutA = (mem_oeA === 1'b1) ? rd_data(mem_addr) : 8'($urandom);
        mem_doutB = (mem_oeB === 1'b1) ? rd_data(mem_addr) : 8'($urandom);
        if (rst_mid) begin
            @(negedge clk) reset_n = 1'b0;
            #1;
            check("rst_mem_we", 32'(mem_we), 32'(0));
            check("rst_mem_oe", 32'({mem_oeA, mem_oeB}), 32'(0));
            check("rst_mem_addr", 32'(mem_addr), 32'(0));
            clkref = 1'b0;
            repeat (2) @(negedge clk);
            check("rst_no_ack", 32'({a_ack, b_ack, c_ack}), 32'(0));
            reset_n = 1'b1;
            model_reset();
            return;
        end
        @(negedge clk) clkref = 1'b0;
        repeat (4) @(negedge clk);
        check("slot_stable_ctl", 32'({mem_we, mem_oeA, mem_oeB}), 32'({e_we, e_oea, e_oeb}));
        check("slot_stable_addr", 32'(mem_addr), 32'(m_addr));
        if (!hold) begin
            if (exp_ack[2]) a_req = 1'b0;
            if (exp_ack[1]) b_req = 1'b0;
            if (exp_ack[0]) c_req = 1'b0;
        end
    endtask

    initial begin
        hold = 0; n_oea = 0; n_we = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_mem", 32'({mem_we, mem_oeA, mem_oeB}), 32'(0));
        check("reset_addr_din", 32'({mem_addr, mem_din}), 32'(0));
        check("reset_acks", 32'({a_ack, b_ack, c_ack}), 32'(0));
        check("reset_douts", 32'({a_dout, b_dout}), 32'(0));
        reset_n = 1'b1;

        // Init hold-off with A read held, then completion with data 0x5A.
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000001;
        repeat (6) slot_step(1'b0);
        check("a_dout_5a", 32'(a_dout), 32'h5A);
        slot_step(1'b0);

        // B and A at the same slot: B first, then A.
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h10;
        b_req = 1'b1; b_addr = 25'h20;
        repeat (3) slot_step(1'b0);

        // A and C held continuously: alternation plus forced refresh slot.
        hold = 1; n_oea = 0; n_we = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h30;
        c_req = 1'b1; c_addr = 25'h40; c_din = 8'h11;
        repeat (12) slot_step(1'b0);
        check("no_starve_a", 32'(n_oea >= 4), 32'(1));
        check("no_starve_c", 32'(n_we >= 4), 32'(1));
        hold = 0; a_req = 1'b0; c_req = 1'b0;
        repeat (2) slot_step(1'b0);

        // C back-to-back writes at the top address.
        hold = 1;
        c_req = 1'b1; c_addr = 25'h1FFFFFF; c_din = 8'hA5;
        repeat (6) slot_step(1'b0);
        hold = 0; c_req = 1'b0;
        repeat (2) slot_step(1'b0);

        // Reset in the middle of an A write slot, then init hold-off restarts.
        a_req = 1'b1; a_we = 1'b1; a_addr = 25'h55; a_din = 8'h77;
        slot_step(1'b1);
        repeat (6) slot_step(1'b0);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            if (!a_req && $urandom_range(1, 0) == 1) begin
                a_req = 1'b1; a_we = 1'($urandom); a_addr = 25'($urandom); a_din = 8'($urandom);
            end
            if (!b_req && $urandom_range(3, 0) == 0) begin
                b_req = 1'b1; b_addr = 25'($urandom);
            end
            if (!c_req && $urandom_range(1, 0) == 1) begin
                c_req = 1'b1; c_addr = 25'($urandom); c_din = 8'($urandom);
            end
            slot_step(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
